// File: rtl/pw_trigger_pkg.sv
// Shared definitions for the pulse-train trigger sequencer: FSM state
// encoding, default widths and the width-0-as-1 helper.
package pw_trigger_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_DELAY   = 3'd2,
        ST_PULSE   = 3'd3,
        ST_DONE    = 3'd4,
        ST_HOLDOFF = 3'd5
    } state_t;

    localparam int DEF_DELAY_WIDTH = 20;
    localparam int DEF_WIDTH_WIDTH = 17;
    localparam int DEF_NUM_PULSES  = 8;
    localparam int DEF_COUNT_WIDTH = 16;

    // A programmed width of 0 still produces a one-cycle pulse.
    function automatic logic [31:0] eff_width(input logic [31:0] w);
        return (w == 32'd0) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/pw_trigger_table.sv
// Per-pulse {delay, width} register file: synchronous write, combinational
// read, cleared by reset.
module pw_trigger_table #(
    parameter int pDELAY_WIDTH = 20,
    parameter int pWIDTH_WIDTH = 17,
    parameter int pNUM_PULSES  = 8,
    localparam int IW = (pNUM_PULSES > 1) ? $clog2(pNUM_PULSES) : 1
) (
    input  logic                    clk,
    input  logic                    reset_i,
    input  logic                    we,
    input  logic [IW-1:0]           waddr,
    input  logic [pDELAY_WIDTH-1:0] wdelay,
    input  logic [pWIDTH_WIDTH-1:0] wwidth,
    input  logic [IW-1:0]           raddr,
    output logic [pDELAY_WIDTH-1:0] rdelay,
    output logic [pWIDTH_WIDTH-1:0] rwidth
);

    logic [pDELAY_WIDTH-1:0] delay_mem [pNUM_PULSES];
    logic [pWIDTH_WIDTH-1:0] width_mem [pNUM_PULSES];

    // Table storage: clear on reset, otherwise write one entry per strobe.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            for (int i = 0; i < pNUM_PULSES; i++) begin
                delay_mem[i] <= '0;
                width_mem[i] <= '0;
            end
        end else if (we) begin
            delay_mem[waddr] <= wdelay;
            width_mem[waddr] <= wwidth;
        end
    end

    assign rdelay = delay_mem[raddr];
    assign rwidth = width_mem[raddr];

endmodule

// File: rtl/pw_trigger_seq.sv
// Pulse-train trigger sequencer. A rising edge of I_match while armed
// plays back 1..pNUM_PULSES delay/width pairs from the table on O_trigger.
// Optional feature: define PW_TRIG_SEQ_HOLDOFF_EN to add I_holdoff and a
// HOLDOFF wait between DONE and re-arming.
//
// Handshake: there is no valid/ready flow here; I_arm, I_disarm and
// I_tbl_we are single-cycle strobes acted on at the edge that samples them,
// and I_match is a level whose rising edge is the only event.
module pw_trigger_seq
    import pw_trigger_pkg::*;
#(
    parameter int pDELAY_WIDTH = DEF_DELAY_WIDTH,
    parameter int pWIDTH_WIDTH = DEF_WIDTH_WIDTH,
    parameter int pNUM_PULSES  = DEF_NUM_PULSES,
    parameter int pCOUNT_WIDTH = DEF_COUNT_WIDTH,
    localparam int IW = (pNUM_PULSES > 1) ? $clog2(pNUM_PULSES) : 1
) (
    input  logic                    trigger_clk,
    input  logic                    reset_i,
    input  logic                    I_arm,
    input  logic                    I_disarm,
    input  logic                    I_auto_rearm,
    input  logic [IW-1:0]           I_num_pulses,
    input  logic                    I_match,
    input  logic                    I_tbl_we,
    input  logic [IW-1:0]           I_tbl_addr,
    input  logic [pDELAY_WIDTH-1:0] I_tbl_delay,
    input  logic [pWIDTH_WIDTH-1:0] I_tbl_width,
`ifdef PW_TRIG_SEQ_HOLDOFF_EN
    input  logic [pDELAY_WIDTH-1:0] I_holdoff,
`endif
    output logic                    O_trigger,
    output logic                    O_armed,
    output logic                    O_busy,
    output logic                    O_done,
    output logic                    O_overrun,
    output logic [pCOUNT_WIDTH-1:0] O_seq_count,
    output logic [2:0]              O_state
);

    // One counter serves delay, pulse width and holdoff; it compares
    // against a terminal value latched when the state is entered.
    localparam int CNT_W = (pDELAY_WIDTH > pWIDTH_WIDTH) ? pDELAY_WIDTH : pWIDTH_WIDTH;

    state_t                  state, state_nx;
    logic [CNT_W-1:0]        cnt, cnt_nx;
    logic [CNT_W-1:0]        lim, lim_nx;
    logic [IW-1:0]           idx, idx_nx;
    logic [IW-1:0]           rd_addr;
    logic [pDELAY_WIDTH-1:0] rd_delay;
    logic [pWIDTH_WIDTH-1:0] rd_width;
    logic                    match_q;
    logic                    match_event;
    logic                    busy_state;

    assign match_event = I_match & ~match_q;
    assign busy_state  = (state == ST_DELAY) || (state == ST_PULSE) ||
                         (state == ST_DONE)  || (state == ST_HOLDOFF);
    assign O_state     = state;

    // Address the entry about to be loaded: delay[0] from ARMED,
    // width[idx] from DELAY, delay[idx+1] from PULSE.
    always_comb begin
        rd_addr = idx;
        if (state == ST_ARMED)      rd_addr = '0;
        else if (state == ST_PULSE) rd_addr = idx + IW'(1);
    end

    pw_trigger_table #(
        .pDELAY_WIDTH(pDELAY_WIDTH),
        .pWIDTH_WIDTH(pWIDTH_WIDTH),
        .pNUM_PULSES (pNUM_PULSES)
    ) u_table (
        .clk    (trigger_clk),
        .reset_i(reset_i),
        .we     (I_tbl_we),
        .waddr  (I_tbl_addr),
        .wdelay (I_tbl_delay),
        .wwidth (I_tbl_width),
        .raddr  (rd_addr),
        .rdelay (rd_delay),
        .rwidth (rd_width)
    );

    // Next-state, counter and table-load decisions; disarm overrides all.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + CNT_W'(1);
        lim_nx   = lim;
        idx_nx   = idx;
        case (state)
            ST_IDLE: begin
                cnt_nx = '0;
                if (I_arm) state_nx = ST_ARMED;
            end
            ST_ARMED: begin
                cnt_nx = '0;
                if (match_event) begin
                    state_nx = ST_DELAY;
                    idx_nx   = '0;
                    lim_nx   = CNT_W'(rd_delay);
                end
            end
            ST_DELAY: begin
                if (cnt == lim) begin
                    state_nx = ST_PULSE;
                    cnt_nx   = '0;
                    lim_nx   = CNT_W'(eff_width(32'(rd_width)) - 32'd1);
                end
            end
            ST_PULSE: begin
                if (cnt == lim) begin
                    cnt_nx = '0;
                    if (idx < I_num_pulses) begin
                        state_nx = ST_DELAY;
                        idx_nx   = idx + IW'(1);
                        lim_nx   = CNT_W'(rd_delay);
                    end else begin
                        state_nx = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                cnt_nx = '0;
`ifdef PW_TRIG_SEQ_HOLDOFF_EN
                if (I_auto_rearm) begin
                    state_nx = ST_HOLDOFF;
                    lim_nx   = CNT_W'(I_holdoff);
                end else begin
                    state_nx = ST_IDLE;
                end
`else
                state_nx = I_auto_rearm ? ST_ARMED : ST_IDLE;
`endif
            end
`ifdef PW_TRIG_SEQ_HOLDOFF_EN
            ST_HOLDOFF: begin
                if (cnt == lim) begin
                    state_nx = ST_ARMED;
                    cnt_nx   = '0;
                end
            end
`endif
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
        if (I_disarm) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
        end
    end

    // State register, counters and registered outputs derived from next state.
    always_ff @(posedge trigger_clk) begin
        if (reset_i) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            lim         <= '0;
            idx         <= '0;
            match_q     <= 1'b0;
            O_trigger   <= 1'b0;
            O_armed     <= 1'b0;
            O_busy      <= 1'b0;
            O_done      <= 1'b0;
            O_overrun   <= 1'b0;
            O_seq_count <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            lim       <= lim_nx;
            idx       <= idx_nx;
            match_q   <= I_match;
            O_trigger <= (state_nx == ST_PULSE);
            O_armed   <= (state_nx == ST_ARMED);
            O_busy    <= (state_nx == ST_DELAY) || (state_nx == ST_PULSE) ||
                         (state_nx == ST_DONE)  || (state_nx == ST_HOLDOFF);
            O_done    <= (state_nx == ST_DONE);
            if (match_event && busy_state)
                O_overrun <= 1'b1;
            else if ((state == ST_IDLE) && I_arm && !I_disarm)
                O_overrun <= 1'b0;
            if ((state == ST_DONE) && (O_seq_count != {pCOUNT_WIDTH{1'b1}}))
                O_seq_count <= O_seq_count + pCOUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pw_trigger_seq.sv
// Bench for pw_trigger_seq: a schedule-based reference model (each accepted
// event expands into a queue of expected per-cycle outputs) checked every
// cycle, plus literal checks of the directed scenarios.
module tb_pw_trigger_seq;
  import pw_trigger_pkg::*;

  localparam int DW = 20;
  localparam int WW = 17;
  localparam int NP = 8;
  localparam int IW = 3;
  localparam int CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int M_IDLE = 0;
  localparam int M_ARMED = 1;
  localparam int M_RUN = 2;

  logic trigger_clk = 1'b0;
  logic reset_i, I_arm, I_disarm, I_auto_rearm, I_match, I_tbl_we;
  logic [IW-1:0] I_num_pulses, I_tbl_addr;
  logic [DW-1:0] I_tbl_delay;
  logic [WW-1:0] I_tbl_width;
`ifdef PW_TRIG_SEQ_HOLDOFF_EN
  logic [DW-1:0] I_holdoff;
`endif
  logic O_trigger, O_armed, O_busy, O_done, O_overrun;
  logic [CW-1:0] O_seq_count;
  logic [2:0] O_state;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  // clock
  always #5 trigger_clk = ~trigger_clk;

  pw_trigger_seq #(
    .pDELAY_WIDTH(DW), .pWIDTH_WIDTH(WW), .pNUM_PULSES(NP), .pCOUNT_WIDTH(CW)
  ) dut (
    .trigger_clk(trigger_clk), .reset_i(reset_i), .I_arm(I_arm), .I_disarm(I_disarm),
    .I_auto_rearm(I_auto_rearm), .I_num_pulses(I_num_pulses), .I_match(I_match),
    .I_tbl_we(I_tbl_we), .I_tbl_addr(I_tbl_addr), .I_tbl_delay(I_tbl_delay),
    .I_tbl_width(I_tbl_width),
`ifdef PW_TRIG_SEQ_HOLDOFF_EN
    .I_holdoff(I_holdoff),
`endif
    .O_trigger(O_trigger), .O_armed(O_armed), .O_busy(O_busy), .O_done(O_done),
    .O_overrun(O_overrun), .O_seq_count(O_seq_count), .O_state(O_state)
  );

  // ---------------- reference model ----------------
  int m_mode = M_IDLE;
  logic [1:0] exp_q[$];   // {trigger, done} per future busy cycle
  logic [1:0] m_cur = 2'b00;
  bit m_match_q = 0;
  int m_tbl_d[NP];
  int m_tbl_w[NP];
  bit e_trig = 0, e_armed = 0, e_busy = 0, e_done = 0, e_ovr = 0;
  int e_cnt = 0;

  task automatic build_schedule();
    int w;
    exp_q.delete();
    for (int i = 0; i <= int'(I_num_pulses); i++) begin
      for (int k = 0; k <= m_tbl_d[i]; k++) exp_q.push_back(2'b00);
      w = (m_tbl_w[i] == 0) ? 1 : m_tbl_w[i];
      for (int k = 0; k < w; k++) exp_q.push_back(2'b10);
    end
    exp_q.push_back(2'b01);
  endtask

  task automatic model_step();
    bit ev, was_busy, was_done;
    ev = I_match && !m_match_q;
    was_busy = (m_mode == M_RUN);
    was_done = was_busy && m_cur[0];
    m_match_q = I_match;
    if (reset_i) begin
      m_mode = M_IDLE; exp_q.delete(); m_cur = 2'b00; m_match_q = 0;
      e_ovr = 0; e_cnt = 0;
      for (int i = 0; i < NP; i++) begin m_tbl_d[i] = 0; m_tbl_w[i] = 0; end
    end else begin
      if (was_busy && ev) e_ovr = 1;
      if (was_done && e_cnt != CNT_MAX) e_cnt++;
      if (I_disarm) begin
        m_mode = M_IDLE; exp_q.delete(); m_cur = 2'b00;
      end else if (m_mode == M_IDLE) begin
        if (I_arm) begin m_mode = M_ARMED; e_ovr = 0; end
      end else if (m_mode == M_ARMED) begin
        if (ev) begin build_schedule(); m_cur = exp_q.pop_front(); m_mode = M_RUN; end
      end else begin
        if (was_done) begin
          if (I_auto_rearm) begin
`ifdef PW_TRIG_SEQ_HOLDOFF_EN
            for (int k = 0; k <= int'(I_holdoff); k++) exp_q.push_back(2'b00);
            m_cur = exp_q.pop_front();
`else
            m_mode = M_ARMED;
`endif
          end else begin
            m_mode = M_IDLE;
          end
        end else if (exp_q.size() == 0) begin
          m_mode = M_ARMED;
        end else begin
          m_cur = exp_q.pop_front();
        end
      end
      if (I_tbl_we) begin
        m_tbl_d[I_tbl_addr] = int'(I_tbl_delay);
        m_tbl_w[I_tbl_addr] = int'(I_tbl_width);
      end
    end
    e_busy = (m_mode == M_RUN);
    e_armed = (m_mode == M_ARMED);
    e_trig = e_busy && m_cur[1];
    e_done = e_busy && m_cur[0];
  endtask

  initial forever begin
    @(posedge trigger_clk);
    model_step();
  end

  // ---------------- scoreboard ----------------
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // every-cycle comparison against the model
  always @(negedge trigger_clk) begin
    if (chk_en) begin
      cmp("trigger", 32'(O_trigger), 32'(e_trig));
      cmp("armed", 32'(O_armed), 32'(e_armed));
      cmp("busy", 32'(O_busy), 32'(e_busy));
      cmp("done", 32'(O_done), 32'(e_done));
      cmp("overrun", 32'(O_overrun), 32'(e_ovr));
      cmp("seq_count", 32'(O_seq_count), 32'(e_cnt));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge trigger_clk);
  endtask

  task automatic wr(input int a, input int d, input int w);
    I_tbl_we = 1; I_tbl_addr = IW'(a); I_tbl_delay = DW'(d); I_tbl_width = WW'(w);
    tick();
    I_tbl_we = 0;
  endtask

  task automatic arm_pulse();
    I_arm = 1; tick(); I_arm = 0;
  endtask

  task automatic disarm_pulse();
    I_disarm = 1; tick(); I_disarm = 0;
  endtask

  task automatic run_trace(input int n, output logic [15:0] tr, output logic [15:0] dn);
    tr = '0; dn = '0;
    for (int k = 0; k < n; k++) begin
      tick();
      tr[k] = O_trigger;
      dn[k] = O_done;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] tr, dn;
    reset_i = 1; I_arm = 0; I_disarm = 0; I_auto_rearm = 0; I_match = 0;
    I_tbl_we = 0; I_tbl_addr = '0; I_tbl_delay = '0; I_tbl_width = '0; I_num_pulses = '0;
`ifdef PW_TRIG_SEQ_HOLDOFF_EN
    I_holdoff = '0;
`endif
    tick(); tick();
    reset_i = 0; chk_en = 1;
    tick();
    cmp("reset_trigger", 32'(O_trigger), 0);
    cmp("reset_busy", 32'(O_busy), 0);
    cmp("reset_state", 32'(O_state), 32'(ST_IDLE));

    // single pulse D=3 W=2
    wr(0, 3, 2);
    arm_pulse();
    I_match = 1;
    run_trace(8, tr, dn);
    cmp("single_trig", 32'(tr), 32'h0030);
    cmp("single_done", 32'(dn), 32'h0040);
    cmp("single_count", 32'(O_seq_count), 1);
    cmp("single_state", 32'(O_state), 32'(ST_IDLE));

    // three-pulse train, match held high
    I_match = 0;
    wr(0, 0, 1); wr(1, 2, 3); wr(2, 1, 1);
    I_num_pulses = 3'd2;
    arm_pulse();
    I_match = 1;
    run_trace(14, tr, dn);
    cmp("train_trig", 32'(tr), 32'h04E2);
    cmp("train_done", 32'(dn), 32'h0800);
    repeat (10) tick();
    cmp("train_one_seq", 32'(O_busy), 0);
    cmp("train_count", 32'(O_seq_count), 2);

    // abort mid-pulse, then arm+disarm together
    I_match = 0;
    wr(0, 2, 4);
    I_num_pulses = '0;
    arm_pulse();
    I_match = 1;
    repeat (5) tick();
    cmp("abort_pre_trig", 32'(O_trigger), 1);
    disarm_pulse();
    cmp("abort_trig", 32'(O_trigger), 0);
    cmp("abort_state", 32'(O_state), 32'(ST_IDLE));
    cmp("abort_count", 32'(O_seq_count), 2);
    I_match = 0;
    I_arm = 1; I_disarm = 1; tick(); I_arm = 0; I_disarm = 0;
    tick();
    cmp("arm_disarm_armed", 32'(O_armed), 0);

    // overrun with auto re-arm
    I_auto_rearm = 1;
    arm_pulse();
    I_match = 1;
    repeat (4) tick();
    I_match = 0; tick();
    I_match = 1; tick();
    cmp("ovr_set", 32'(O_overrun), 1);
    I_match = 0;
    repeat (5) tick();
    cmp("ovr_rearmed", 32'(O_armed), 1);
    cmp("ovr_count", 32'(O_seq_count), 3);
    I_match = 1;
    repeat (2) tick();
    cmp("ovr_next_seq", 32'(O_busy), 1);
    I_match = 0;
    repeat (10) tick();
    disarm_pulse();
    cmp("ovr_sticky", 32'(O_overrun), 1);
    arm_pulse();
    cmp("ovr_cleared", 32'(O_overrun), 0);
    I_auto_rearm = 0;
    disarm_pulse();

    // width 0 gives a single-cycle pulse
    wr(0, 1, 0);
    arm_pulse();
    I_match = 1;
    run_trace(6, tr, dn);
    cmp("w0_trig", 32'(tr), 32'h0004);
    cmp("w0_done", 32'(dn), 32'h0008);
    I_match = 0;

    // reset mid-sequence
    wr(0, 1, 5);
    arm_pulse();
    I_match = 1;
    repeat (4) tick();
    cmp("rst_pre_trig", 32'(O_trigger), 1);
    reset_i = 1; I_match = 0;
    tick();
    reset_i = 0;
    cmp("rst_mid_trig", 32'(O_trigger), 0);
    cmp("rst_mid_busy", 32'(O_busy), 0);
    cmp("rst_mid_ovr", 32'(O_overrun), 0);
    cmp("rst_mid_count", 32'(O_seq_count), 0);

    // counter saturation at 3 after 5 sequences
    I_auto_rearm = 1;
    arm_pulse();
    for (int i = 0; i < 5; i++) begin
      I_match = 1; tick(); I_match = 0;
      repeat (5) tick();
      if (i == 1) cmp("sat_count2", 32'(O_seq_count), 2);
    end
    cmp("sat_count", 32'(O_seq_count), 3);
    I_auto_rearm = 0;
    disarm_pulse();

    // randomized phase
    for (int n = 0; n < 4000; n++) begin
      I_arm = ($urandom_range(0, 15) == 0);
      I_disarm = ($urandom_range(0, 99) == 0);
      reset_i = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 5) == 0) I_match = ~I_match;
      if ($urandom_range(0, 49) == 0) I_auto_rearm = ~I_auto_rearm;
      I_tbl_we = 0;
      if (m_mode == M_IDLE) begin
        if ($urandom_range(0, 2) == 0) begin
          I_tbl_we = 1;
          I_tbl_addr = IW'($urandom_range(0, NP - 1));
          I_tbl_delay = DW'($urandom_range(0, 5));
          I_tbl_width = WW'($urandom_range(0, 4));
        end
        if ($urandom_range(0, 3) == 0) I_num_pulses = IW'($urandom_range(0, 3));
`ifdef PW_TRIG_SEQ_HOLDOFF_EN
        if ($urandom_range(0, 3) == 0) I_holdoff = DW'($urandom_range(0, 3));
`endif
      end
      tick();
    end
    I_arm = 0; I_disarm = 0; reset_i = 0; I_tbl_we = 0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
